// File: rtl/pipelined_adder.sv
// Pipelined adder: carry chain split into CHUNK-bit slices, one per stage.
// Signed/unsigned mode, optional saturation, valid/ready on both sides.
module pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_signed,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int L      = STAGES - 1;
    localparam int PS     = (STAGES > 1) ? STAGES - 1 : 1;

    logic stall;

    logic             cv, cc, cg, ct;
    logic [WIDTH-1:0] ca, cb;

    logic [PS-1:0]    pv, pc, pg, pt;
    logic [WIDTH-1:0] pa [PS];
    logic [WIDTH-1:0] pb [PS];
    logic [WIDTH-1:0] ps [PS];

    logic [STAGES-1:0] sv, sc, sg, st, nc;
    logic [WIDTH-1:0]  sa [STAGES];
    logic [WIDTH-1:0]  sb [STAGES];
    logic [WIDTH-1:0]  ss [STAGES];
    logic [WIDTH-1:0]  ns [STAGES];
    logic [CHUNK:0]    t  [STAGES];

    logic             cmsb, ovf;
    logic [WIDTH-1:0] fsum;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        sv = '0;
        sc = '0;
        sg = '0;
        st = '0;
        nc = '0;
        for (int k = 0; k < STAGES; k++) begin
            sa[k] = '0;
            sb[k] = '0;
            ss[k] = '0;
            ns[k] = '0;
            t[k]  = '0;
        end
        sv[0] = cv;
        sa[0] = ca;
        sb[0] = cb;
        sc[0] = cc;
        sg[0] = cg;
        st[0] = ct;
        for (int k = 1; k < STAGES; k++) begin
            sv[k] = pv[k-1];
            sa[k] = pa[k-1];
            sb[k] = pb[k-1];
            ss[k] = ps[k-1];
            sc[k] = pc[k-1];
            sg[k] = pg[k-1];
            st[k] = pt[k-1];
        end
        // each stage adds its own slice and merges it into the partial sum
        for (int k = 0; k < STAGES; k++) begin
            t[k]  = {1'b0, CHUNK'(sa[k] >> (k * CHUNK))}
                  + {1'b0, CHUNK'(sb[k] >> (k * CHUNK))}
                  + (CHUNK + 1)'(sc[k]);
            ns[k] = ss[k] | (WIDTH'(t[k][CHUNK-1:0]) << (k * CHUNK));
            nc[k] = t[k][CHUNK];
        end
        cmsb = t[L][CHUNK-1] ^ sa[L][WIDTH-1] ^ sb[L][WIDTH-1];
        ovf  = sg[L] ? (cmsb ^ nc[L]) : nc[L];
        fsum = ns[L];
        if (st[L] && ovf) begin
            unique case (1'b1)
                !sg[L]:        fsum = '1;
                sa[L][WIDTH-1]: fsum = {1'b1, {(WIDTH-1){1'b0}}};
                default:       fsum = {1'b0, {(WIDTH-1){1'b1}}};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv        <= 1'b0;
            ca        <= '0;
            cb        <= '0;
            cc        <= 1'b0;
            cg        <= 1'b0;
            ct        <= 1'b0;
            pv        <= '0;
            pc        <= '0;
            pg        <= '0;
            pt        <= '0;
            for (int k = 0; k < PS; k++) begin
                pa[k] <= '0;
                pb[k] <= '0;
                ps[k] <= '0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            cv <= in_valid;
            ca <= in_a;
            cb <= in_b;
            cc <= in_cin;
            cg <= in_signed;
            ct <= in_sat;
            for (int k = 0; k < STAGES - 1; k++) begin
                pv[k] <= sv[k];
                pa[k] <= sa[k];
                pb[k] <= sb[k];
                ps[k] <= ns[k];
                pc[k] <= nc[k];
                pg[k] <= sg[k];
                pt[k] <= st[k];
            end
            out_valid <= sv[L];
            out_sum   <= fsum;
            out_cout  <= nc[L];
            out_ovf   <= ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector bench for pipelined_adder (WIDTH=8, CHUNK=4).
// Hand-computed results, backpressure stream and mid-flight reset.
module tb_pipelined_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_signed;
    logic       in_sat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       out_ovf;

    int n_vec = 0;
    int n_err = 0;

    pipelined_adder #(.WIDTH(8), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_signed (in_signed),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one isolated beat; result must appear exactly two edges after accept
    task automatic send(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic cin,
                        input logic sg,
                        input logic sat,
                        input logic [7:0] es,
                        input logic ec,
                        input logic eo);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_signed = sg;
        in_sat    = sat;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".early"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sum"}, 32'(out_sum), 32'(es));
        check({tag, ".cout"}, 32'(out_cout), 32'(ec));
        check({tag, ".ovf"}, 32'(out_ovf), 32'(eo));
    endtask

    logic [7:0] got_q [$];
    logic       fire;
    logic       drain;
    logic [7:0] dsum;
    int         j;
    int         seen;
    int         stall_left;
    int         first_d;
    int         last_d;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_signed = 1'b0;
        in_sat    = 1'b0;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.sum", 32'(out_sum), 32'd0);
        check("rst.cout", 32'(out_cout), 32'd0);
        check("rst.ovf", 32'(out_ovf), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rel.ready", 32'(in_ready), 32'd1);

        send("u_add", 8'd20, 8'd34, 1'b0, 1'b0, 1'b0, 8'h36, 1'b0, 1'b0);
        send("s_ovf", 8'd56, 8'd74, 1'b0, 1'b1, 1'b0, 8'h82, 1'b0, 1'b1);
        send("s_sat", 8'd56, 8'd74, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1);
        send("u_cry", 8'd123, 8'd255, 1'b0, 1'b0, 1'b0, 8'h7A, 1'b1, 1'b1);
        send("u_sat", 8'd123, 8'd255, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        send("s_nov", 8'd123, 8'd255, 1'b0, 1'b1, 1'b0, 8'h7A, 1'b1, 1'b0);
        send("s_cin", 8'hFE, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        send("s_neg", 8'h80, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);

        // backpressure stream: beats (i, i+1), 3-cycle stall on first result
        j          = 0;
        seen       = 0;
        stall_left = 0;
        first_d    = -1;
        last_d     = -1;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 40 && got_q.size() < 5; cyc++) begin
            if (out_valid && seen == 0) begin
                seen       = 1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            in_valid  = (j < 5);
            in_a      = 8'(j);
            in_b      = 8'(j + 1);
            in_cin    = 1'b0;
            in_signed = 1'b0;
            in_sat    = 1'b0;
            #1;
            if (!out_ready) begin
                check("bp.rdy", 32'(in_ready), 32'd0);
                check("bp.hold", 32'(out_sum), 32'd1);
            end
            fire  = in_valid && in_ready;
            drain = out_valid && out_ready;
            dsum  = out_sum;
            @(posedge clk);
            #1;
            if (fire) j++;
            if (drain) begin
                got_q.push_back(dsum);
                if (first_d < 0) first_d = cyc;
                last_d = cyc;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp.sent", 32'(j), 32'd5);
        check("bp.count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < got_q.size(); i++)
            check("bp.res", 32'(got_q[i]), 32'(2 * i + 1));
        check("bp.first", 32'(first_d), 32'd6);
        check("bp.rate", 32'(last_d - first_d), 32'd4);

        // reset while two beats are in flight
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = 8'd1;
        in_b     = 8'd1;
        @(posedge clk);
        #1;
        in_a = 8'd2;
        in_b = 8'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid.valid", 32'(out_valid), 32'd0);
        check("mid.ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("mid.drop", 32'(out_valid), 32'd0);
        end
        send("post", 8'd100, 8'd27, 1'b1, 1'b0, 1'b0, 8'd128, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
